// File: rtl/fp_addsub_pipe_if.sv
// Operand/result bundle for fp_addsub_pipe: one sample per cycle, no backpressure.
interface fp_addsub_pipe_if #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
);
    localparam int unsigned W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic [W-1:0] result;
    logic [2:0]   flags;

    modport master (
        output in_valid, op_sub, a, b,
        input  out_valid, result, flags
    );

    modport slave (
        input  in_valid, op_sub, a, b,
        output out_valid, result, flags
    );
endinterface

// File: rtl/fp_addsub_pipe.sv
// Three-stage floating-point add/subtract: unpack/compare, align/add, normalise/round/pack.
// Subnormal inputs read as zero; results below the normal range flush to zero.
module fp_addsub_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input logic             clk,
    input logic             rst,
    fp_addsub_pipe_if.slave bus
);
    localparam int unsigned W     = 1 + EXP_W + MAN_W;
    localparam int unsigned SIG_W = MAN_W + 4;
    localparam int unsigned D_MAX = MAN_W + 3;
    localparam int unsigned D_W   = $clog2(D_MAX + 1);
    localparam int unsigned LZ_W  = $clog2(SIG_W + 1);
    localparam int unsigned E_W   = EXP_W + LZ_W + 1;
    localparam int unsigned M_W   = MAN_W + 2;
    localparam int          EMAX  = (2 ** EXP_W) - 1;
    localparam logic [EXP_W-1:0] EXP_ONES  = '1;
    localparam logic [MAN_W-1:0] QNAN_FRAC = {1'b1, {(MAN_W-1){1'b0}}};

    logic             sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
    logic [EXP_W-1:0] ea, eb, ediff;
    logic [MAN_W-1:0] fa, fb, fa_z, fb_z;

    logic             v1_q, s1_sign_q, s1_sign_d, s1_sub_q, s1_sub_d;
    logic [EXP_W-1:0] s1_exp_q, s1_exp_d;
    logic [MAN_W:0]   s1_ma_q, s1_ma_d, s1_mb_q, s1_mb_d;
    logic [D_W-1:0]   s1_d_q, s1_d_d;
    // {nan, inf, inf_sign, both_zero, both_zero_sign}
    logic [4:0]       s1_spec_q, s1_spec_d;

    always_comb begin
        sa     = bus.a[W-1];
        sb     = bus.b[W-1] ^ bus.op_sub;
        ea     = bus.a[W-2 -: EXP_W];
        eb     = bus.b[W-2 -: EXP_W];
        fa     = bus.a[MAN_W-1:0];
        fb     = bus.b[MAN_W-1:0];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (ea == EXP_ONES) && (fa == '0);
        b_inf  = (eb == EXP_ONES) && (fb == '0);
        a_nan  = (ea == EXP_ONES) && (fa != '0);
        b_nan  = (eb == EXP_ONES) && (fb != '0);
        fa_z   = a_zero ? '0 : fa;
        fb_z   = b_zero ? '0 : fb;
        swap   = {eb, fb_z} > {ea, fa_z};

        s1_sign_d = swap ? sb : sa;
        s1_exp_d  = swap ? eb : ea;
        s1_ma_d   = swap ? {~b_zero, fb_z} : {~a_zero, fa_z};
        s1_mb_d   = swap ? {~a_zero, fa_z} : {~b_zero, fb_z};
        ediff     = swap ? (eb - ea) : (ea - eb);
        s1_d_d    = (int'(ediff) > int'(D_MAX)) ? D_W'(D_MAX) : D_W'(ediff);
        s1_sub_d  = sa ^ sb;
        s1_spec_d = {a_nan | b_nan | (a_inf & b_inf & (sa ^ sb)),
                     a_inf | b_inf,
                     a_inf ? sa : sb,
                     a_zero & b_zero,
                     sa & sb};
    end

    logic [SIG_W-1:0] ma_ext, mb_ext, mb_al, lost_mask;
    logic             v2_q, s2_sign_q;
    logic [EXP_W-1:0] s2_exp_q;
    logic [SIG_W:0]   s2_sum_q, s2_sum_d;
    logic [4:0]       s2_spec_q;

    // Bits shifted past the sticky position are folded into it, so a
    // saturated distance still leaves B visible as a nonzero sticky.
    always_comb begin
        ma_ext    = {s1_ma_q, 3'b000};
        mb_ext    = {s1_mb_q, 3'b000};
        lost_mask = (SIG_W'(1) << s1_d_q) - SIG_W'(1);
        mb_al     = (mb_ext >> s1_d_q) | SIG_W'(|(mb_ext & lost_mask));
        s2_sum_d  = s1_sub_q ? ({1'b0, ma_ext} - {1'b0, mb_al})
                             : ({1'b0, ma_ext} + {1'b0, mb_al});
    end

    logic [LZ_W-1:0]       lzc;
    logic [SIG_W-1:0]      norm;
    logic signed [E_W-1:0] exp_ext, e_n, e_r;
    logic [M_W-1:0]        mant;
    logic [MAN_W-1:0]      frac;
    logic                  round_up;
    logic [W-1:0]          res_d;
    logic [2:0]            flg_d;

    always_comb begin
        lzc = LZ_W'(SIG_W);
        for (int unsigned i = 0; i < SIG_W; i++) begin
            if (s2_sum_q[i]) lzc = LZ_W'(SIG_W - 1 - i);
        end
    end

    always_comb begin
        exp_ext = $signed(E_W'(s2_exp_q));
        if (s2_sum_q[SIG_W]) begin
            norm = {s2_sum_q[SIG_W:2], s2_sum_q[1] | s2_sum_q[0]};
            e_n  = exp_ext + $signed(E_W'(1));
        end else begin
            norm = s2_sum_q[SIG_W-1:0] << lzc;
            e_n  = exp_ext - $signed(E_W'(lzc));
        end
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant     = {1'b0, norm[SIG_W-1:3]} + M_W'(round_up);
        if (mant[MAN_W+1]) begin
            e_r  = e_n + $signed(E_W'(1));
            frac = mant[MAN_W:1];
        end else begin
            e_r  = e_n;
            frac = mant[MAN_W-1:0];
        end

        flg_d = 3'b000;
        if (s2_spec_q[4]) begin
            res_d = {1'b0, EXP_ONES, QNAN_FRAC};
            flg_d = 3'b100;
        end else if (s2_spec_q[3]) begin
            res_d = {s2_spec_q[2], EXP_ONES, {MAN_W{1'b0}}};
        end else if (s2_spec_q[1]) begin
            res_d = {s2_spec_q[0], {(W-1){1'b0}}};
        end else if (s2_sum_q == '0) begin
            res_d = '0;
        end else if (e_r >= EMAX) begin
            res_d = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
            flg_d = 3'b010;
        end else if (e_r <= 0) begin
            res_d = {s2_sign_q, {(W-1){1'b0}}};
            flg_d = 3'b001;
        end else begin
            res_d = {s2_sign_q, e_r[EXP_W-1:0], frac};
        end
    end

    logic         out_valid_q;
    logic [W-1:0] result_q;
    logic [2:0]   flags_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            v1_q        <= bus.in_valid;
            v2_q        <= v1_q;
            out_valid_q <= v2_q;
            if (v2_q) begin
                result_q <= res_d;
                flags_q  <= flg_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        s1_sign_q <= s1_sign_d;
        s1_exp_q  <= s1_exp_d;
        s1_ma_q   <= s1_ma_d;
        s1_mb_q   <= s1_mb_d;
        s1_d_q    <= s1_d_d;
        s1_sub_q  <= s1_sub_d;
        s1_spec_q <= s1_spec_d;
        s2_sign_q <= s1_sign_q;
        s2_exp_q  <= s1_exp_q;
        s2_sum_q  <= s2_sum_d;
        s2_spec_q <= s1_spec_q;
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe: directed plan vectors plus random traffic checked each cycle
// against an exact wide-integer reference with round-to-nearest-even.
module tb_fp_addsub_pipe;
    localparam int EW    = 8;
    localparam int MW    = 23;
    localparam int W     = 1 + EW + MW;
    localparam int EMAX  = (1 << EW) - 1;
    localparam int BIG   = MW + 2 + EMAX + 8;
    localparam int DEPTH = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_addsub_pipe_if #(.EXP_W(EW), .MAN_W(MW)) bus ();
    fp_addsub_pipe #(.EXP_W(EW), .MAN_W(MW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_vec  = 0;
    int unsigned n_err  = 0;
    int unsigned edge_no = 0;
    logic         exp_v [DEPTH];
    logic [W-1:0] exp_r [DEPTH];
    logic [2:0]   exp_f [DEPTH];
    logic [W-1:0] last_r = '0;
    logic [2:0]   last_f = '0;

    // Exact value of a op b as a wide integer, then rounded to MW+1 significant bits.
    task automatic ref_model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                             output logic [W-1:0] r, output logic [2:0] f);
        logic sa, sb, s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        int ea, eb, emin, p, e, sh;
        logic [BIG-1:0] xa, xb, mag, q, rem, half;
        sa = a[W-1];
        sb = b[W-1] ^ op;
        s  = sa;
        ea = int'(a[W-2 -: EW]);
        eb = int'(b[W-2 -: EW]);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        a_inf  = (ea == EMAX) && (a[MW-1:0] == '0);
        b_inf  = (eb == EMAX) && (b[MW-1:0] == '0);
        a_nan  = (ea == EMAX) && (a[MW-1:0] != '0);
        b_nan  = (eb == EMAX) && (b[MW-1:0] != '0);
        r = '0;
        f = 3'b000;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            r = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
            f = 3'b100;
            return;
        end
        if (a_inf || b_inf) begin
            r = {(a_inf ? sa : sb), {EW{1'b1}}, {MW{1'b0}}};
            return;
        end
        if (a_zero && b_zero) begin
            r = {(sa & sb), {(W-1){1'b0}}};
            return;
        end
        xa = a_zero ? '0 : BIG'({1'b1, a[MW-1:0]});
        xb = b_zero ? '0 : BIG'({1'b1, b[MW-1:0]});
        if (a_zero) ea = eb;
        if (b_zero) eb = ea;
        emin = (ea < eb) ? ea : eb;
        xa = xa << (ea - emin);
        xb = xb << (eb - emin);
        if (sa == sb) begin
            mag = xa + xb; s = sa;
        end else if (xa >= xb) begin
            mag = xa - xb; s = sa;
        end else begin
            mag = xb - xa; s = sb;
        end
        if (mag == '0) return;
        p = 0;
        for (int i = 0; i < BIG; i++) if (mag[i]) p = i;
        e = emin + p - MW;
        if (p > MW) begin
            sh   = p - MW;
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = BIG'(1) << (sh - 1);
            if ((rem > half) || ((rem == half) && q[0])) q = q + BIG'(1);
            if (q[MW+1]) begin
                q = q >> 1;
                e = e + 1;
            end
        end else begin
            q = mag << (MW - p);
        end
        if (e >= EMAX) begin
            r = {s, {EW{1'b1}}, {MW{1'b0}}};
            f = 3'b010;
        end else if (e <= 0) begin
            r = {s, {(W-1){1'b0}}};
            f = 3'b001;
        end else begin
            r = {s, e[EW-1:0], q[MW-1:0]};
        end
    endtask

    task automatic check_outputs();
        n_vec++;
        assert (bus.out_valid === exp_v[edge_no]) else begin
            n_err++;
            $error("FAIL out_valid edge %0d: observed %b expected %b", edge_no, bus.out_valid, exp_v[edge_no]);
        end
        if (exp_v[edge_no]) begin
            last_r = exp_r[edge_no];
            last_f = exp_f[edge_no];
        end
        n_vec++;
        assert (bus.result === last_r) else begin
            n_err++;
            $error("FAIL result edge %0d: observed %h expected %h", edge_no, bus.result, last_r);
        end
        n_vec++;
        assert (bus.flags === last_f) else begin
            n_err++;
            $error("FAIL flags edge %0d: observed %b expected %b", edge_no, bus.flags, last_f);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_no++;
        #1;
        check_outputs();
    endtask

    task automatic drive(input logic v, input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.in_valid = v;
        bus.op_sub   = op;
        bus.a        = a;
        bus.b        = b;
    endtask

    task automatic apply_exp(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] er, input logic [2:0] ef);
        drive(1'b1, op, a, b);
        exp_v[edge_no + 3] = 1'b1;
        exp_r[edge_no + 3] = er;
        exp_f[edge_no + 3] = ef;
        tick();
    endtask

    task automatic apply_ref(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic [2:0]   f;
        ref_model(op, a, b, r, f);
        apply_exp(op, a, b, r, f);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'($urandom), W'($urandom), W'($urandom));
            tick();
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        for (int unsigned k = edge_no + 1; k < DEPTH; k++) exp_v[k] = 1'b0;
        last_r = '0;
        last_f = '0;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [W-1:0] rnd_normal(input int lo, input int hi);
        return {1'($urandom), 8'($urandom_range(hi, lo)), 23'($urandom)};
    endfunction

    function automatic logic [W-1:0] rnd_operand();
        int unsigned k = $urandom_range(19, 0);
        logic [MW-1:0] fr = 23'($urandom);
        if (k == 0) return {1'($urandom), 8'h00, 23'h0};
        if (k == 1) return {1'($urandom), 8'hFF, 23'h0};
        if (k == 2) return {1'($urandom), 8'hFF, fr | 23'h1};
        if (k == 3) return {1'($urandom), 8'h00, fr};
        if (k < 12) return rnd_normal(120, 134);
        return rnd_normal(1, 254);
    endfunction

    initial begin
        logic [W-1:0] ra, rb;
        for (int k = 0; k < DEPTH; k++) begin
            exp_v[k] = 1'b0;
            exp_r[k] = '0;
            exp_f[k] = '0;
        end
        drive(1'b0, 1'b0, '0, '0);
        pulse_reset();
        pulse_reset();
        idle(1);

        apply_exp(1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 3'b000);
        idle(3);
        apply_exp(1'b1, 32'h40400000, 32'h3F800000, 32'h40000000, 3'b000);
        apply_exp(1'b1, 32'h3F800000, 32'h40400000, 32'hC0000000, 3'b000);
        apply_exp(1'b0, 32'h3F800000, 32'hBF800000, 32'h00000000, 3'b000);
        apply_exp(1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000, 3'b000);
        apply_exp(1'b0, 32'h3F800000, 32'h33800001, 32'h3F800001, 3'b000);
        apply_exp(1'b0, 32'h3F800001, 32'h33800000, 32'h3F800002, 3'b000);
        apply_exp(1'b1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 3'b100);
        apply_exp(1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3'b010);
        apply_exp(1'b1, 32'h00800001, 32'h00800000, 32'h00000000, 3'b001);
        apply_exp(1'b0, 32'h80000000, 32'h80000000, 32'h80000000, 3'b000);
        idle(4);

        for (int i = 0; i < 8; i++) apply_ref(1'($urandom), rnd_normal(110, 140), rnd_normal(110, 140));
        idle(2);

        apply_ref(1'b0, rnd_normal(110, 140), rnd_normal(110, 140));
        apply_ref(1'b1, rnd_normal(110, 140), rnd_normal(110, 140));
        pulse_reset();
        idle(3);
        apply_exp(1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 3'b000);
        idle(4);

        for (int i = 0; i < 150; i++) begin
            ra = rnd_operand();
            rb = (i % 4 == 0) ? {1'($urandom), ra[W-2:MW], ra[MW-1:0] ^ 23'($urandom_range(255, 0))}
                              : rnd_operand();
            apply_ref(1'($urandom), ra, rb);
            if ($urandom_range(4, 0) == 0) idle(1);
        end
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point adder/subtractor for the IIR datapath.
- Takes two operands and a per-sample op select. Returns a = a ± b with round-to-nearest-even and special-value handling.
- Fixed 3-cycle latency at full throughput, with a valid flag travelling alongside the data.
- Default widths give binary32. Other EXP_W/MAN_W pairs give custom formats for the filter accumulator.

Parameters:
EXP_W, 8, exponent field width; bias = 2^(EXP_W-1)-1
MAN_W, 23, stored fraction width (hidden bit not stored)
W, 1+EXP_W+MAN_W, total word width (derived; do not override)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operands valid this cycle
op_sub  in  1  0: a+b, 1: a-b
a  in  W  operand a {sign, exp, frac}
b  in  W  operand b
out_valid  out  1  result valid
result  out  W  rounded sum/difference
flags  out  3  {invalid, overflow, underflow}, valid with out_valid

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- On reset: out_valid=0, result=0, flags=0, all internal valid bits cleared.
- Reset mid-operation discards in-flight samples. The first valid output after reset comes from an in_valid sampled after rst deasserts.
- Latency and handshake:
  - in_valid sampled at edge N produces out_valid=1 with result/flags at edge N+3.
  - A new operand pair may be accepted every cycle. There is no backpressure.
  - When out_valid=0, result and flags hold their last values.
- Stage 1 (unpack and compare):
  - Effective sign of b is sb_eff = b[W-1] ^ op_sub.
  - Subnormal inputs (exp=0) are treated as signed zero (DAZ).
  - Classify each operand as zero, inf (exp all-ones, frac=0) or NaN (exp all-ones, frac≠0).
  - Compare magnitudes {exp, frac} and swap so the larger operand is A.
  - Compute d = eA - eB, saturating at MAN_W+3.
  - Effective subtract = sA ^ sb_eff.
- Stage 2 (align and add):
  - Form significands with the hidden bit plus 3 extra bits (guard, round, sticky).
  - Shift B right by d. Sticky is the OR of all bits shifted out.
  - Add or subtract, keeping one carry bit.
- Stage 3 (normalise, round, pack):
  - On carry-out: shift right by 1 (sticky absorbs the dropped bit) and increment the exponent.
  - Otherwise: left-shift by the leading-zero count and decrement the exponent.
  - Round to nearest even: increment if G & (R | S | lsb). Mantissa overflow from rounding renormalises with exponent +1.
- Special cases, with priority top to bottom:
  - Any NaN input, or inf - inf (effective): result = canonical qNaN {0, all-ones, 1, 0...}, invalid=1.
  - Any inf: result = that inf with its effective sign.
  - Exact zero result:
    - both operands zero with equal effective sign → zero with that sign;
    - all other exact-zero cases → +0.
  - Final exponent ≥ all-ones: result = ±inf, overflow=1.
  - Final exponent ≤ 0: result = ±0 (flush-to-zero), underflow=1.
- Result sign is sA, except where the special cases above override it.
- flags=0 for samples that hit none of the cases above.

Test Plan:
- Basic add: a=0x3F800000, b=0x40000000, op_sub=0 → result=0x40400000, flags=0, out_valid exactly 3 cycles after in_valid.
- Subtract and sign: a=0x40400000, b=0x3F800000, op_sub=1 → 0x40000000. Swap operands → 0xC0000000. Also a=0x3F800000, b=0xBF800000, op_sub=0 → 0x00000000.
- Rounding:
  - 0x3F800000 + 0x33800000 (exact tie) → 0x3F800000 (round to even).
  - 0x3F800000 + 0x33800001 → 0x3F800001.
  - 0x3F800001 + 0x33800000 → 0x3F800002.
- Specials:
  - 0x7F800000 - 0x7F800000 → 0x7FC00000, flags=100.
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, flags=010.
  - 0x00800001 - 0x00800000 → 0x00000000, flags=001.
  - 0x80000000 + 0x80000000 → 0x80000000.
- Throughput: drive 8 back-to-back random normal pairs with in_valid held high, then a 2-cycle gap → 8 consecutive correct outputs matching a real-arithmetic model, followed by a 2-cycle out_valid gap.
- Reset mid-flight: assert rst for 1 cycle while 2 samples are in the pipe → out_valid=0 and result=0 on the following cycles, no stale outputs, and correct output 3 cycles after the next in_valid.
